// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited IMEM requests, in-order PC tagging, 2-entry instruction buffer.
// Latency: IMEM response in cycle N is presented to decode in cycle N+1; a redirect flushes on the next edge.
// Backpressure: inst_ready low fills the buffer and withholds IMEM credits; imem_req_ready low holds the request.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of force-aligning them.

// Small generic FIFO. Depth must be a power of two; flush wins over push/pop.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       async_reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          wr_en;
    logic          rd_en;

    assign wr_en    = push && (count != CW'(DEPTH));
    assign rd_en    = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end
endmodule

module fetch_unit #(
    parameter int              bits      = 32,
    parameter logic [bits-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2     // only 2 is supported
) (
    input  logic            clk,
    input  logic            async_reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [bits-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [bits-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [bits-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [bits-1:0] inst_data,
    output logic [bits-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [bits-1:0]   fetch_pc;
    logic [1:0]        outstanding;
    logic [1:0]        drop_cnt;
    logic [1:0]        outstanding_after_rsp;
    logic              run;
    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     tag_count;
    logic [bits-1:0]   tag_pc;
    logic [2*bits-1:0] buf_head;
    logic              credit_ok;
    logic              req_fire;
    logic              rsp_live;
    logic              rsp_take;
    logic              rsp_push;
    logic              inst_pop;
    logic              fetch_halt;
    logic [bits-1:0]   redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redirect_misaligned;
    logic halt_q;

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_target     = redirect_pc;
    assign fetch_halt          = halt_q;

    // One-cycle trap pulse on a misaligned redirect; fetch stays halted until an aligned redirect.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            misalign_trap <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            misalign_trap <= redirect_misaligned;
            if (redirect_valid) halt_q <= redirect_misaligned;
        end
    end
`else
    // Misaligned targets are silently aligned down to a word boundary.
    assign redirect_target = redirect_pc & ~bits'(3);
    assign fetch_halt      = 1'b0;
`endif

    // Credits count buffered plus in-flight (including doomed) requests; same-cycle pops are not credited.
    assign credit_ok      = (3'(buf_count) + 3'(outstanding)) < 3'(BUF_DEPTH);
    assign imem_req_valid = run && credit_ok && !redirect_valid && !fetch_halt;
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. from before a reset) are ignored outright.
    assign rsp_live              = imem_rsp_valid && (outstanding != 2'd0);
    assign rsp_take              = rsp_live && (drop_cnt == 2'd0) && (tag_count != '0);
    assign rsp_push              = rsp_take && !redirect_valid;
    assign outstanding_after_rsp = outstanding - 2'(rsp_live);

    assign inst_valid = (buf_count != '0);
    assign inst_pop   = inst_valid && inst_ready && !redirect_valid;
    assign inst_pc    = buf_head[2*bits-1:bits];
    assign inst_data  = buf_head[bits-1:0];

    // Requests are held back for one cycle after reset release so the first one starts on a clean edge.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) run <= 1'b0;
        else              run <= 1'b1;
    end

    // Fetch PC: a redirect overrides any same-cycle acceptance.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset)        fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_target;
        else if (req_fire)       fetch_pc <= fetch_pc + bits'(4);
    end

    // In-flight accounting; on redirect every remaining in-flight response becomes one to discard.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else if (redirect_valid) begin
            outstanding <= outstanding_after_rsp;
            drop_cnt    <= outstanding_after_rsp;
        end else begin
            outstanding <= outstanding_after_rsp + 2'(req_fire);
            if (rsp_live && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
        end
    end

    // PCs of live requests, in issue order, matched to responses as they return.
    fetch_fifo #(.W(bits), .DEPTH(2)) u_tag_q (
        .clk         (clk),
        .async_reset (async_reset),
        .flush       (redirect_valid),
        .push        (req_fire),
        .push_dat    (fetch_pc),
        .pop         (rsp_take),
        .head_dat    (tag_pc),
        .count       (tag_count)
    );

    // Instruction buffer feeding decode, entries are {pc, instruction}.
    fetch_fifo #(.W(2*bits), .DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk         (clk),
        .async_reset (async_reset),
        .flush       (redirect_valid),
        .push        (rsp_push),
        .push_dat    ({tag_pc, imem_rsp_data}),
        .pop         (inst_pop),
        .head_dat    (buf_head),
        .count       (buf_count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with an IMEM model and an instruction scoreboard.
// The driver models requests/responses per cycle; a separate monitor checks every decode handshake.
// Define FETCH_MISALIGN_TRAP_EN to exercise the misaligned-redirect trap build.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        async_reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.bits(32), .RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .async_reset    (async_reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap  (misalign_trap)
`endif
    );

    typedef struct { logic [31:0] addr; int due; bit killed; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] dat; } ins_t;

    req_t        pend[$];    // requests the IMEM still owes a response for
    ins_t        exp_q[$];   // instructions decode should see, in order
    logic [31:0] model_pc;
    bit          running;
    bit          halt;
    bit          trap_exp;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          checks = 0;
    int          errors = 0;

    // IMEM contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        model_pc = RST_PC;
        running  = 1'b0;
        halt     = 1'b0;
        trap_exp = 1'b0;
        last_due = cyc;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst_data"}, inst_data, 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, RST_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk({tag, "_misalign_trap"}, 32'(misalign_trap), 32'd0);
`endif
    endtask

    // One clock cycle of stimulus plus reference-model update.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy, input bit irdy);
        bit   rsp;
        bit   acc;
        bit   exp_req;
        int   lat;
        req_t r;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        inst_ready     = irdy;
        rsp            = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
        #1;
        exp_req = running && !redir && !halt && ((exp_q.size() + pend.size()) < 2);
        chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
        chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_trap", 32'(misalign_trap), 32'(trap_exp));
`endif
        if (imem_req_valid) chk("imem_addr", imem_addr, model_pc);
        acc = exp_req && rdy;
        if (rsp) begin
            r = pend.pop_front();
            if (!r.killed && !redir) exp_q.push_back('{pc: r.addr, dat: mem_word(r.addr)});
        end
        trap_exp = 1'b0;
        if (redir) begin
            foreach (pend[i]) pend[i].killed = 1'b1;
            exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            halt     = (rpc[1:0] != 2'b00);
            trap_exp = halt;
            model_pc = rpc;
`else
            model_pc = rpc & ~32'h3;
`endif
        end else if (acc) begin
            lat      = $urandom_range(lat_max, lat_min);
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{addr: model_pc, due: last_due, killed: 1'b0});
            model_pc = model_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic release_reset(input bit stale);
        @(negedge clk);
        async_reset    = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        imem_rsp_valid = stale;
        imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        chk("release_req_valid", 32'(imem_req_valid), 32'd0);
        chk("release_inst_valid", 32'(inst_valid), 32'd0);
        running  = 1'b1;
        last_due = cyc;
        cyc++;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        #3;
        async_reset = 1'b0;
        #1;
        reset_check("mid_rst");
        cyc++;
        model_reset();
        repeat (2) @(negedge clk);
        cyc += 2;
    endtask

    // Advance until the model has exactly n requests in flight, issuing only while below n.
    task automatic wait_pend(input int n);
        int k = 0;
        while (pend.size() != n && k < 40) begin
            cycle(1'b0, 32'h0, pend.size() < n, 1'b1);
            k++;
        end
        checks++;
        if (pend.size() != n) begin
            errors++;
            $display("FAIL wait_pend: got %0d in flight, required %0d", pend.size(), n);
        end
    endtask

    // Scoreboard monitor: every decode handshake must match the next expected instruction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (async_reset === 1'b1 && inst_valid && inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h, required none", inst_pc);
                end else begin
                    ins_t e;
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_data", inst_data, e.dat);
                end
            end
        end
    end

    initial begin
        async_reset    = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        reset_check("por");
        release_reset(1'b0);

        // Streaming with 1-cycle IMEM and decode always ready.
        lat_min = 1; lat_max = 1;
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        // Decode stalls: buffer fills and requests stop, then drain in order.
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        wait_pend(2);
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect while a request is being offered to a ready IMEM.
        lat_min = 1; lat_max = 1;
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h40, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Misaligned redirect, then an aligned one.
        cycle(1'b1, 32'h102, 1'b1, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h200, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Address wrap at the top of the address space.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom & 32'h0000_3FFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            cycle($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end
        cycle(1'b1, 32'h300, 1'b1, 1'b1);
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Reset with one request in flight; its late response must be ignored.
        lat_min = 3; lat_max = 3;
        wait_pend(1);
        mid_reset();
        release_reset(1'b1);
        lat_min = 1; lat_max = 1;
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
